// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART TX frame controller: state encoding and line levels.
package uart_tx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Shift register and bit counter for the TX data phase; presents the bit that goes
// on the line at the next edge.
module uart_tx_serializer #(
  parameter int Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [Width-1:0] data_i,
  output logic             ser_bit_o,
  output logic             ser_done_o
);

  localparam int CntW = $clog2(Width);
  localparam logic [CntW-1:0] LastIdx = CntW'(Width - 1);

  logic [Width-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  assign ser_done_o = (cnt_q == LastIdx);
  // While shifting, the bit leaving for the line is the one about to move into bit 0.
  assign ser_bit_o  = shift_i ? shreg_q[1] : shreg_q[0];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shreg_d = data_i;
      cnt_d   = '0;
    end else if (shift_i && !ser_done_o) begin
      shreg_d = {1'b0, shreg_q[Width-1:1]};
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame controller: start bit, LSB-first data, optional parity, stop bit.
// TX_OUT and Busy are registered; the stop cycle already shows Busy low.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int Width = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [Width-1:0] P_DATA,
  input  logic             DATA_VALID,
  input  logic             PAR_EN,
  input  logic             Parity_bit,
  output logic             TX_OUT,
  output logic             Busy
);

  state_e state_q, state_d;
  logic   tx_q, tx_d;
  logic   busy_q, busy_d;
  logic   par_en_q, par_en_d;
  logic   ser_load, ser_shift, ser_bit, ser_done;

  uart_tx_serializer #(
    .Width(Width)
  ) u_serializer (
    .clk_i     (CLK),
    .rst_i     (RST),
    .load_i    (ser_load),
    .shift_i   (ser_shift),
    .data_i    (P_DATA),
    .ser_bit_o (ser_bit),
    .ser_done_o(ser_done)
  );

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    par_en_d  = par_en_q;
    ser_load  = 1'b0;
    ser_shift = 1'b0;

    unique case (state_q)
      // Busy is already low during the stop bit, so a waiting word starts with no gap.
      IDLE, STOP: begin
        if (DATA_VALID) begin
          ser_load = 1'b1;
          par_en_d = PAR_EN;
          state_d  = START;
          tx_d     = START_BIT;
          busy_d   = 1'b1;
        end else begin
          state_d  = IDLE;
          tx_d     = STOP_BIT;
          busy_d   = 1'b0;
        end
      end
      START: begin
        state_d = DATA;
        tx_d    = ser_bit;
      end
      DATA: begin
        if (ser_done) begin
          state_d = par_en_q ? PARITY : STOP;
          tx_d    = par_en_q ? Parity_bit : STOP_BIT;
          busy_d  = par_en_q;
        end else begin
          ser_shift = 1'b1;
          tx_d      = ser_bit;
        end
      end
      PARITY: begin
        state_d = STOP;
        tx_d    = STOP_BIT;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        tx_d    = STOP_BIT;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      tx_q     <= STOP_BIT;
      busy_q   <= 1'b0;
      par_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      par_en_q <= par_en_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: stimulus queues the expected line/Busy value of
// every cycle; a negedge monitor pops and compares.
module tb_uart_tx_ctrl;

  localparam int Width = 8;

  logic             CLK = 1'b0;
  logic             RST;
  logic [Width-1:0] P_DATA;
  logic             DATA_VALID;
  logic             PAR_EN;
  logic             Parity_bit;
  logic             TX_OUT;
  logic             Busy;

  typedef struct packed {
    logic tx;
    logic busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_popped = 0;

  uart_tx_ctrl #(
    .Width(Width)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_EN    (PAR_EN),
    .Parity_bit(Parity_bit),
    .TX_OUT    (TX_OUT),
    .Busy      (Busy)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (TX_OUT !== e.tx) begin
        n_fail++;
        $display("FAIL tx_out cycle %0d: got %b, expected %b", n_popped, TX_OUT, e.tx);
      end
      n_checks++;
      if (Busy !== e.busy) begin
        n_fail++;
        $display("FAIL busy cycle %0d: got %b, expected %b", n_popped, Busy, e.busy);
      end
      n_popped++;
    end
  end

  task automatic push_exp(input logic tx, input logic busy);
    exp_t e;
    e.tx   = tx;
    e.busy = busy;
    exp_q.push_back(e);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push_exp(1'b1, 1'b0);
  endtask

  // Reference frame built from the inputs captured at accept; bit 0 goes out first.
  task automatic model(input logic [Width-1:0] d, input logic pen, input logic par,
                       output logic [31:0] line, output int len);
    line    = '0;
    line[0] = 1'b0;
    for (int i = 0; i < Width; i++) line[1+i] = d[i];
    if (pen) line[Width+1] = par;
    len       = Width + 2 + int'(pen);
    line[len-1] = 1'b1;
  endtask

  // mode 1: scramble P_DATA/PAR_EN after accept; mode 2: stray strobe of 0x12 at cycle 4.
  task automatic send(input logic [Width-1:0] d, input logic pen,
                      input logic [31:0] hand, input int hand_len,
                      input int idle_after, input bit hold, input int mode);
    logic [31:0] line;
    int          len;
    P_DATA     = d;
    PAR_EN     = pen;
    Parity_bit = ^d;
    DATA_VALID = 1'b1;
    @(posedge CLK); #1;
    if (!hold) DATA_VALID = 1'b0;
    if (hand_len > 0) begin
      line = hand;
      len  = hand_len;
    end else begin
      model(d, pen, ^d, line, len);
    end
    for (int i = 0; i < len; i++) push_exp(line[i], i < len - 1);
    push_idle(idle_after);
    for (int k = 1; k < len + idle_after; k++) begin
      @(posedge CLK); #1;
      if (mode == 1) begin
        P_DATA = ~d;
        PAR_EN = ~pen;
      end
      if (mode == 2) begin
        if (k == 4) begin
          DATA_VALID = 1'b1;
          P_DATA     = 8'h12;
        end else if (k == 5 && !hold) begin
          DATA_VALID = 1'b0;
        end
      end
    end
  endtask

  initial begin
    logic [31:0] line;
    int          len;

    RST        = 1'b1;
    DATA_VALID = 1'b0;
    P_DATA     = '0;
    PAR_EN     = 1'b0;
    Parity_bit = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    push_idle(2);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Parity frame 0xA5: 0,1,0,1,0,0,1,0,1,0,1
    send(8'hA5, 1'b1, 32'b10101001010, 11, 2, 1'b0, 0);
    // No-parity frame 0x00: 0 x9 then stop
    send(8'h00, 1'b0, 32'b1000000000, 10, 2, 1'b0, 0);
    // Strobe while busy: 0xFF frame unchanged, 0x12 never appears
    send(8'hFF, 1'b1, 32'b10111111110, 11, 2, 1'b0, 2);

    // Reset at cycle 5 of a 0x3C frame, with a competing strobe that must lose
    P_DATA     = 8'h3C;
    PAR_EN     = 1'b1;
    Parity_bit = ^P_DATA;
    DATA_VALID = 1'b1;
    @(posedge CLK); #1;
    DATA_VALID = 1'b0;
    model(8'h3C, 1'b1, 1'b0, line, len);
    for (int i = 0; i < 5; i++) push_exp(line[i], 1'b1);
    push_idle(2);
    repeat (4) begin
      @(posedge CLK); #1;
    end
    RST        = 1'b1;
    DATA_VALID = 1'b1;
    P_DATA     = 8'h99;
    @(posedge CLK); #1;
    RST        = 1'b0;
    DATA_VALID = 1'b0;
    @(posedge CLK); #1;
    send(8'h3C, 1'b1, '0, 0, 2, 1'b0, 0);

    // Back-to-back with DATA_VALID held: 0x81 then 0x7E, no idle gap
    send(8'h81, 1'b0, 32'b1100000010, 10, 0, 1'b1, 0);
    send(8'h7E, 1'b0, 32'b1011111100, 10, 2, 1'b0, 0);

    // Mid-frame input changes against the capture-at-accept model
    send(8'h5A, 1'b0, '0, 0, 1, 1'b0, 1);
    send(8'hC3, 1'b1, '0, 0, 1, 1'b0, 1);
    send(8'h01, 1'b1, '0, 0, 2, 1'b0, 1);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge CLK);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected cycles left, required 0", exp_q.size());
    end
    repeat (2) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
